// File: rtl/hazard_scheduler_if.sv
// Decode/execute/writeback signal bundle between the core pipeline and the hazard scheduler.
// Latency: none, wires only. Backpressure: the scheduler returns du_stall_o/xu_bubble_o on this bundle.
// Ports: decode operands (du_*), writeback (wb_*), retire/redirect (xu_*), and status outputs.
interface hazard_scheduler_if #(
  parameter int STALL_CNT_W = 16
);
  logic                   du_valid_i;
  logic [4:0]             du_rs0_i;
  logic [4:0]             du_rs1_i;
  logic                   du_rs0_used_i;
  logic                   du_rs1_used_i;
  logic [4:0]             du_rdt_i;
  logic                   du_rd_wr_i;
  logic                   xu_branch_flush_i;
  logic                   wb_valid_i;
  logic [4:0]             wb_rdt_i;
  logic                   xu_retire_i;
  logic                   du_stall_o;
  logic                   xu_bubble_o;
  logic                   du_flush_o;
  logic [1:0]             state_o;
  logic [3:0]             inflight_o;
  logic [STALL_CNT_W-1:0] stall_cnt_o;

  // Pipeline side: drives decode/writeback/retire and observes the stall controls.
  modport master (
    output du_valid_i, du_rs0_i, du_rs1_i, du_rs0_used_i, du_rs1_used_i,
           du_rdt_i, du_rd_wr_i, xu_branch_flush_i, wb_valid_i, wb_rdt_i, xu_retire_i,
    input  du_stall_o, xu_bubble_o, du_flush_o, state_o, inflight_o, stall_cnt_o
  );

  // Scheduler side.
  modport slave (
    input  du_valid_i, du_rs0_i, du_rs1_i, du_rs0_used_i, du_rs1_used_i,
           du_rdt_i, du_rd_wr_i, xu_branch_flush_i, wb_valid_i, wb_rdt_i, xu_retire_i,
    output du_stall_o, xu_bubble_o, du_flush_o, state_o, inflight_o, stall_cnt_o
  );
endinterface

// File: rtl/hazard_scheduler.sv
// Decode->execute hazard scheduler: register scoreboard, in-flight count, flush window, stall counter.
// Latency: du_stall_o/xu_bubble_o are combinational (zero cycles); scoreboard/FSM update on the next edge.
// Backpressure: freezes decode and bubbles execute on RAW/WAW/capacity hazards; never stalls during a flush.
// Ports: clock_i, nreset_i (async active-low), bus (hazard_scheduler_if.slave) carrying all pipeline signals.
module hazard_scheduler #(
  parameter int MAX_INFLIGHT = 4,
  parameter int FLUSH_CYCLES = 2,
  parameter int STALL_CNT_W  = 16
) (
  input  logic                    clock_i,
  input  logic                    nreset_i,
  hazard_scheduler_if.slave       bus
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    FLUSH = 2'd2
  } state_t;

  localparam logic [3:0] MAX_LIM    = 4'(MAX_INFLIGHT);
  localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES);

  logic [31:0]            pend_q;
  logic [31:0]            pend_d;
  logic [3:0]             inflight_q;
  logic [3:0]             inflight_d;
  state_t                 state_q;
  logic [2:0]             flush_cnt_q;
  logic                   flush_q;
  logic [STALL_CNT_W-1:0] stall_cnt_q;

  logic rs0_haz;
  logic rs1_haz;
  logic waw_haz;
  logic cap_haz;
  logic hazard;
  logic in_flush;
  logic du_stall;
  logic xu_bubble;
  logic issue;

  // A writeback landing this cycle bypasses the pending bit, so it does not count as a hazard.
  assign rs0_haz = bus.du_rs0_used_i && (bus.du_rs0_i != 5'd0) && pend_q[bus.du_rs0_i]
                   && !(bus.wb_valid_i && (bus.wb_rdt_i == bus.du_rs0_i));
  assign rs1_haz = bus.du_rs1_used_i && (bus.du_rs1_i != 5'd0) && pend_q[bus.du_rs1_i]
                   && !(bus.wb_valid_i && (bus.wb_rdt_i == bus.du_rs1_i));
  assign waw_haz = bus.du_rd_wr_i && (bus.du_rdt_i != 5'd0) && pend_q[bus.du_rdt_i]
                   && !(bus.wb_valid_i && (bus.wb_rdt_i == bus.du_rdt_i));
  // A retire in the same cycle frees the slot the new instruction needs.
  assign cap_haz = (inflight_q == MAX_LIM) && !bus.xu_retire_i;
  assign hazard  = bus.du_valid_i && (rs0_haz || rs1_haz || waw_haz || cap_haz);

  assign in_flush  = (state_q == FLUSH);
  assign du_stall  = hazard && !in_flush && !bus.xu_branch_flush_i;
  assign xu_bubble = du_stall || !bus.du_valid_i || in_flush || bus.xu_branch_flush_i;
  assign issue     = bus.du_valid_i && !xu_bubble;

  // Clear first, then set, so an issue to the register being written back leaves it pending.
  always_comb begin
    pend_d = pend_q;
    if (bus.wb_valid_i) begin
      pend_d[bus.wb_rdt_i] = 1'b0;
    end
    if (issue && bus.du_rd_wr_i) begin
      pend_d[bus.du_rdt_i] = 1'b1;
    end
    pend_d[0] = 1'b0;
  end

  // Issue and retire together cancel; a retire with nothing outstanding is dropped.
  always_comb begin
    inflight_d = inflight_q;
    if (issue && !bus.xu_retire_i) begin
      inflight_d = inflight_q + 4'd1;
    end else if (!issue && bus.xu_retire_i && (inflight_q != 4'd0)) begin
      inflight_d = inflight_q - 4'd1;
    end
  end

  always_ff @(posedge clock_i or negedge nreset_i) begin
    if (!nreset_i) begin
      pend_q      <= '0;
      inflight_q  <= '0;
      stall_cnt_q <= '0;
    end else begin
      pend_q     <= pend_d;
      inflight_q <= inflight_d;
      if (du_stall && (stall_cnt_q != '1)) begin
        stall_cnt_q <= stall_cnt_q + STALL_CNT_W'(1);
      end
    end
  end

  // Control FSM. A redirect wins from any state and (re)loads the window length.
  always_ff @(posedge clock_i or negedge nreset_i) begin
    if (!nreset_i) begin
      state_q     <= RUN;
      flush_cnt_q <= '0;
      flush_q     <= 1'b0;
    end else if (bus.xu_branch_flush_i) begin
      state_q     <= FLUSH;
      flush_cnt_q <= FLUSH_LOAD;
      flush_q     <= 1'b1;
    end else begin
      case (state_q)
        FLUSH: begin
          if (flush_cnt_q <= 3'd1) begin
            state_q     <= RUN;
            flush_cnt_q <= '0;
            flush_q     <= 1'b0;
          end else begin
            flush_cnt_q <= flush_cnt_q - 3'd1;
          end
        end
        RUN: begin
          if (du_stall) begin
            state_q <= STALL;
          end
        end
        STALL: begin
          if (!du_stall) begin
            state_q <= RUN;
          end
        end
        default: begin
          state_q <= RUN;
        end
      endcase
    end
  end

  assign bus.du_stall_o  = du_stall;
  assign bus.xu_bubble_o = xu_bubble;
  assign bus.du_flush_o  = flush_q;
  assign bus.state_o     = state_q;
  assign bus.inflight_o  = inflight_q;
  assign bus.stall_cnt_o = stall_cnt_q;

  // A retire with no outstanding instruction indicates a pipeline bookkeeping bug upstream.
  retire_at_zero_a : assert property (@(posedge clock_i) disable iff (!nreset_i)
    !(bus.xu_retire_i && (inflight_q == 4'd0)));

endmodule

// File: tb/tb_hazard_scheduler.sv
module tb_hazard_scheduler;
  localparam int MAXI = 4;
  localparam int FLC  = 2;
  localparam int SCW  = 4;
  localparam int SCMAX = (1 << SCW) - 1;

  logic clk;
  logic nreset;

  hazard_scheduler_if #(.STALL_CNT_W(SCW)) bus ();

  hazard_scheduler #(
    .MAX_INFLIGHT(MAXI),
    .FLUSH_CYCLES(FLC),
    .STALL_CNT_W (SCW)
  ) dut (
    .clock_i (clk),
    .nreset_i(nreset),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: which registers have an unretired writer, how many instructions
  // are outstanding, how many flush cycles remain, and whether last cycle stalled.
  bit m_pend[32];
  int m_inflight;
  int m_flush_left;
  bit m_prev_stall;
  int m_stall_cnt;
  bit e_stall, e_bubble, e_issue;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    foreach (m_pend[i]) m_pend[i] = 1'b0;
    m_inflight   = 0;
    m_flush_left = 0;
    m_prev_stall = 1'b0;
    m_stall_cnt  = 0;
  endtask

  function automatic bit reads_pending(bit used, logic [4:0] r);
    return used && (r != 0) && m_pend[r] && !(bus.wb_valid_i && bus.wb_rdt_i == r);
  endfunction

  task automatic model_eval();
    bit haz;
    bit flushing;
    flushing = (m_flush_left > 0);
    haz = reads_pending(bus.du_rs0_used_i, bus.du_rs0_i)
       || reads_pending(bus.du_rs1_used_i, bus.du_rs1_i)
       || reads_pending(bus.du_rd_wr_i, bus.du_rdt_i)
       || (m_inflight == MAXI && !bus.xu_retire_i);
    e_stall  = bus.du_valid_i && haz && !flushing && !bus.xu_branch_flush_i;
    e_bubble = e_stall || !bus.du_valid_i || flushing || bus.xu_branch_flush_i;
    e_issue  = bus.du_valid_i && !e_bubble;
  endtask

  task automatic check_all();
    int e_state;
    model_eval();
    e_state = (m_flush_left > 0) ? 2 : (m_prev_stall ? 1 : 0);
    chk("stall",     32'(bus.du_stall_o),  32'(e_stall));
    chk("bubble",    32'(bus.xu_bubble_o), 32'(e_bubble));
    chk("flush",     32'(bus.du_flush_o),  32'(m_flush_left > 0));
    chk("state",     32'(bus.state_o),     32'(e_state));
    chk("inflight",  32'(bus.inflight_o),  32'(m_inflight));
    chk("stall_cnt", 32'(bus.stall_cnt_o), 32'(m_stall_cnt));
  endtask

  task automatic model_update();
    model_eval();
    if (bus.wb_valid_i) m_pend[bus.wb_rdt_i] = 1'b0;
    if (e_issue && bus.du_rd_wr_i && bus.du_rdt_i != 0) m_pend[bus.du_rdt_i] = 1'b1;
    m_inflight = m_inflight + int'(e_issue) - int'(bus.xu_retire_i);
    if (bus.xu_branch_flush_i) m_flush_left = FLC;
    else if (m_flush_left > 0) m_flush_left--;
    m_prev_stall = e_stall;
    if (e_stall && m_stall_cnt < SCMAX) m_stall_cnt++;
  endtask

  // Inputs are driven after a falling edge; step checks, advances the model and the clock.
  task automatic step();
    #1;
    check_all();
    model_update();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    bus.du_valid_i = 0; bus.du_rs0_i = 0; bus.du_rs1_i = 0;
    bus.du_rs0_used_i = 0; bus.du_rs1_used_i = 0; bus.du_rdt_i = 0; bus.du_rd_wr_i = 0;
    bus.xu_branch_flush_i = 0; bus.wb_valid_i = 0; bus.wb_rdt_i = 0; bus.xu_retire_i = 0;
  endtask

  task automatic dec(input logic [4:0] rs0, input bit u0, input logic [4:0] rs1, input bit u1,
                     input logic [4:0] rdt, input bit wr);
    bus.du_valid_i = 1; bus.du_rs0_i = rs0; bus.du_rs0_used_i = u0;
    bus.du_rs1_i = rs1; bus.du_rs1_used_i = u1; bus.du_rdt_i = rdt; bus.du_rd_wr_i = wr;
  endtask

  // Retire everything and write back every pending register.
  task automatic drain();
    for (int r = 1; r < 32; r++) begin
      if (m_pend[r]) begin
        idle(); bus.wb_valid_i = 1; bus.wb_rdt_i = 5'(r); step();
      end
    end
    while (m_inflight > 0) begin
      idle(); bus.xu_retire_i = 1; step();
    end
    idle();
  endtask

  initial begin
    model_reset();
    idle();
    nreset = 0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_state",     32'(bus.state_o),     0);
    chk("rst_inflight",  32'(bus.inflight_o),  0);
    chk("rst_flush",     32'(bus.du_flush_o),  0);
    chk("rst_bubble",    32'(bus.xu_bubble_o), 1);
    chk("rst_stall_cnt", 32'(bus.stall_cnt_o), 0);
    nreset = 1;
    @(negedge clk);

    // RAW on x5 with writeback bypass
    dec(1, 0, 2, 0, 5, 1); step();
    dec(5, 1, 0, 0, 6, 0);
    #1 chk("raw_stall", 32'(bus.du_stall_o), 1);
    chk("raw_bubble", 32'(bus.xu_bubble_o), 1);
    step();
    #1 chk("raw_state", 32'(bus.state_o), 1);
    bus.wb_valid_i = 1; bus.wb_rdt_i = 5;
    #1 chk("raw_bypass", 32'(bus.du_stall_o), 0);
    chk("raw_issue", 32'(bus.xu_bubble_o), 0);
    step();
    idle();
    #1 chk("raw_cnt", 32'(bus.stall_cnt_o), 1);
    drain();

    // x0 never pending
    dec(0, 0, 0, 0, 0, 1); step();
    dec(0, 1, 0, 1, 3, 0);
    #1 chk("x0_nostall", 32'(bus.du_stall_o), 0);
    step();
    drain();

    // WAW on x7
    dec(0, 0, 0, 0, 7, 1); step();
    dec(0, 0, 0, 0, 7, 1);
    #1 chk("waw_stall", 32'(bus.du_stall_o), 1);
    step(); step();
    bus.wb_valid_i = 1; bus.wb_rdt_i = 7;
    #1 chk("waw_release", 32'(bus.du_stall_o), 0);
    step();
    drain();

    // Capacity
    repeat (MAXI) begin dec(0, 0, 0, 0, 0, 0); step(); end
    dec(0, 0, 0, 0, 0, 0);
    #1 chk("cap_stall", 32'(bus.du_stall_o), 1);
    chk("cap_inflight", 32'(bus.inflight_o), MAXI);
    step();
    bus.xu_retire_i = 1;
    #1 chk("cap_retire_issue", 32'(bus.du_stall_o), 0);
    step();
    idle();
    #1 chk("cap_inflight_kept", 32'(bus.inflight_o), MAXI);
    drain();

    // Flush while stalled, then a re-armed flush
    dec(0, 0, 0, 0, 10, 1); step();
    dec(10, 1, 0, 0, 0, 0); step();
    bus.xu_branch_flush_i = 1;
    #1 chk("fl_nostall", 32'(bus.du_stall_o), 0);
    step();
    bus.xu_branch_flush_i = 0; bus.du_valid_i = 0;
    #1 chk("fl_c1", 32'(bus.du_flush_o), 1);
    step();
    #1 chk("fl_c2", 32'(bus.du_flush_o), 1);
    step();
    #1 chk("fl_end", 32'(bus.du_flush_o), 0);
    chk("fl_run", 32'(bus.state_o), 0);
    bus.xu_branch_flush_i = 1; step();
    bus.xu_branch_flush_i = 0; step();
    bus.xu_branch_flush_i = 1;
    #1 chk("fl2_c2", 32'(bus.du_flush_o), 1);
    step();
    bus.xu_branch_flush_i = 0;
    #1 chk("fl2_c3", 32'(bus.du_flush_o), 1);
    step();
    #1 chk("fl2_c4", 32'(bus.du_flush_o), 1);
    step();
    #1 chk("fl2_end", 32'(bus.du_flush_o), 0);
    step();
    drain();

    // Set wins over same-cycle clear on x9
    dec(0, 0, 0, 0, 9, 1); step();
    dec(0, 0, 0, 0, 9, 1); bus.wb_valid_i = 1; bus.wb_rdt_i = 9; step();
    idle(); dec(9, 1, 0, 0, 0, 0);
    #1 chk("collide_pend", 32'(bus.du_stall_o), 1);
    // Keep stalling to push the counter into saturation
    repeat (20) step();
    #1 chk("sat_cnt", 32'(bus.stall_cnt_o), SCMAX);
    drain();

    // Randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      idle();
      bus.du_valid_i        = ($urandom_range(0, 3) != 0);
      bus.du_rs0_i          = 5'($urandom_range(0, 7));
      bus.du_rs1_i          = 5'($urandom_range(0, 7));
      bus.du_rs0_used_i     = 1'($urandom);
      bus.du_rs1_used_i     = 1'($urandom);
      bus.du_rdt_i          = 5'($urandom_range(0, 7));
      bus.du_rd_wr_i        = 1'($urandom);
      bus.wb_valid_i        = 1'($urandom);
      bus.wb_rdt_i          = 5'($urandom_range(0, 7));
      bus.xu_branch_flush_i = ($urandom_range(0, 19) == 0);
      bus.xu_retire_i       = (m_inflight > 0) && ($urandom_range(0, 2) != 0);
      step();
    end

    // Reset in the middle of a flush window
    idle(); bus.du_valid_i = 1; bus.du_rd_wr_i = 1; bus.du_rdt_i = 4; step();
    bus.xu_branch_flush_i = 1; step();
    idle(); #1;
    nreset = 0;
    #1 chk("mid_rst_flush", 32'(bus.du_flush_o), 0);
    chk("mid_rst_state", 32'(bus.state_o), 0);
    chk("mid_rst_inflight", 32'(bus.inflight_o), 0);
    chk("mid_rst_cnt", 32'(bus.stall_cnt_o), 0);
    model_reset();
    @(negedge clk);
    nreset = 1;
    @(negedge clk);
    dec(4, 1, 0, 0, 0, 0);
    #1 chk("mid_rst_pend", 32'(bus.du_stall_o), 0);
    step();
    idle(); step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/hazard_scheduler.md
Name: hazard_scheduler

Overview:
- Pipeline controller between decode and execute.
- Keeps a register scoreboard of in-flight destination writes and counts outstanding instructions.
- Freezes decode on RAW, WAW or capacity hazards and injects bubbles into execute while decode is frozen.
- Sequences a fixed-length flush window after a branch redirect and counts stall cycles for performance monitoring.

Parameters:
- MAX_INFLIGHT, 4, maximum number of issued-but-unretired instructions (range 1..15).
- FLUSH_CYCLES, 2, number of cycles du_flush_o stays high after a redirect (range 1..7).
- STALL_CNT_W, 16, width of the saturating stall-cycle counter.

Ports:
- clock_i  in  1  core clock.
- nreset_i  in  1  asynchronous active-low reset.
- du_valid_i  in  1  decode holds a real instruction (not a bubble).
- du_rs0_i  in  5  source register 0 of the decode instruction.
- du_rs1_i  in  5  source register 1 of the decode instruction.
- du_rs0_used_i  in  1  rs0 is read by the instruction.
- du_rs1_used_i  in  1  rs1 is read by the instruction.
- du_rdt_i  in  5  destination register.
- du_rd_wr_i  in  1  instruction writes rdt.
- xu_branch_flush_i  in  1  execute redirect pulse.
- wb_valid_i  in  1  writeback of wb_rdt_i this cycle.
- wb_rdt_i  in  5  writeback destination register.
- xu_retire_i  in  1  one instruction retires this cycle.
- du_stall_o  out  1  freeze decode (drives decode xu_stall_i).
- xu_bubble_o  out  1  execute receives a NOP this cycle.
- du_flush_o  out  1  flush window active.
- state_o  out  2  0=RUN, 1=STALL, 2=FLUSH.
- inflight_o  out  4  outstanding instruction count.
- stall_cnt_o  out  STALL_CNT_W  saturating count of stalled cycles.

Behaviour:
- Reset (async, nreset_i low):
  - pend[31:0]=0, inflight=0, state=RUN, flush counter=0, stall_cnt=0.
  - du_stall_o=0, xu_bubble_o=1, du_flush_o=0.
- Source hazard for rsN: du_rsN_used_i & rsN!=0 & pend[rsN] & ~(wb_valid_i & wb_rdt_i==rsN). The writeback bypass means a same-cycle writeback resolves the hazard.
- WAW hazard: du_rd_wr_i & rdt!=0 & pend[rdt] & ~(wb_valid_i & wb_rdt_i==rdt).
- Capacity hazard: inflight==MAX_INFLIGHT & ~xu_retire_i.
- hazard = du_valid_i & (rs0 hazard | rs1 hazard | WAW hazard | capacity hazard).
- du_stall_o = hazard & state!=FLUSH & ~xu_branch_flush_i. This is combinational with zero latency.
- xu_bubble_o = du_stall_o | ~du_valid_i | state==FLUSH | xu_branch_flush_i.
- Issue = du_valid_i & ~xu_bubble_o:
  - sets pend[rdt] if du_rd_wr_i & rdt!=0;
  - increments inflight.
- Writeback: clears pend[wb_rdt_i]. pend[0] is always 0.
- Same-register issue-set and writeback-clear in one cycle: set wins.
- inflight next value = inflight + issue - xu_retire_i. Simultaneous issue and retire leaves it unchanged. Retire at 0 is ignored and must be flagged by an assertion.
- FSM, evaluated in this priority order:
  - Any state, xu_branch_flush_i=1: go to FLUSH, load flush counter with FLUSH_CYCLES. A flush arriving during FLUSH reloads the counter.
  - FLUSH: du_flush_o=1. The counter decrements each cycle; when it reaches 1, go to RUN the next cycle. du_flush_o is high for exactly FLUSH_CYCLES cycles.
  - RUN: go to STALL when du_stall_o=1.
  - STALL: stay while du_stall_o=1; go to RUN when it is 0.
- The scoreboard is not cleared by a flush; squashed instructions were never issued.
- stall_cnt increments every cycle du_stall_o=1 and saturates at all-ones.
- Reset asserted mid-operation clears everything immediately, including the flush window.

Test Plan:
- Reset: hold nreset_i low 3 cycles -> state_o=0, inflight_o=0, du_flush_o=0, xu_bubble_o=1, stall_cnt_o=0.
- RAW: issue writer to x5; next cycle decode reads x5 (rs0_used) -> du_stall_o=1, xu_bubble_o=1, state_o=1. Assert wb_valid_i with wb_rdt_i=5 -> same cycle du_stall_o=0, issue occurs, stall_cnt_o=1.
- x0 and WAW:
  - writer to x0 -> pend stays 0; dependent reader of x0 never stalls.
  - writer to x7 followed by a second writer to x7 -> stall until x7 writeback.
- Capacity (MAX_INFLIGHT=4): 4 independent issues with no retire -> 5th stalls with inflight_o=4. Retire in the same cycle -> 5th issues and inflight_o stays 4.
- Flush:
  - pulse xu_branch_flush_i while stalled -> du_stall_o=0 that cycle, du_flush_o high exactly 2 cycles, then state_o=0.
  - second pulse in flush cycle 2 -> window extends 2 more cycles.
- Set/clear collision and saturation:
  - issue to x9 while wb clears x9 -> pend[9]=1.
  - STALL_CNT_W=4 with 20 stall cycles -> stall_cnt_o=15.
